uart_rx_char: RTL and testbench
===============================

# uart_rx_char

Serial character receiver feeding the byte-wide case converter. Deserializes an asynchronous 8N1 line (optional even parity) into one 8-bit character per frame and holds it in a one-entry output register under a valid/ready handshake. `data[7]` drives the converter's first (MSB) input and `data[0]` its last. Line errors are reported as single-cycle pulses and never produce a character.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period. Minimum 4. The bench uses 16.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rxd` in 1: serial line, idle high, LSB first, asynchronous to `clk`.
- `data` out 8: received character, MSB = bit 7.
- `data_valid` out 1: `data` holds an unconsumed character.
- `data_ready` in 1: downstream accepts `data` on a cycle where `data_valid` is also high.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `overrun` out 1: one-cycle pulse; a character completed while the holding register was full.
- `parity_err` out 1: one-cycle pulse; exists only when parity is compiled in.

## Operation
- Reset: `rxd` is synchronized through 2 flops, both reset to 1. The bit counter is reset to 0.
- Reset values: `data`=0x00, `data_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, FSM=IDLE, all counters 0.
- IDLE: wait for a low on the synchronized line, then load the bit timer and enter START.
- START: at CLKS_PER_BIT/2 (integer division), sample the line.
  - Low: enter DATA.
  - High: treat as a glitch and return to IDLE with no error.
- DATA: sample every CLKS_PER_BIT cycles. Shift in 8 bits, LSB first. Bit index 0..7 wraps to 0 on exit. Then go to PARITY if enabled, otherwise STOP.
- PARITY: sample one bit; even parity over the 8 data bits plus the parity bit.
- STOP: sample one bit.
  - High and no parity error: the frame is good; go to IDLE.
  - Low: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until the synchronized line is high, then go to IDLE. This absorbs a break condition as one error only.
- Holding register, on a good frame:
  - `data_valid`=0, or `data_valid`=1 with `data_ready`=1 in the same cycle: load `data`, set `data_valid`=1.
  - Otherwise: keep the old `data`, pulse `overrun`, drop the new byte.
- Handshake:
  - `data_valid`, once set, stays set and `data` is held stable until the consuming handshake.
  - A handshake with no new frame clears `data_valid`.
  - `data_ready` while `data_valid`=0 has no effect.
- Reset mid-frame: all state returns to reset values immediately. A partially received frame is lost with no error pulse. After reset the receiver resynchronizes on the next falling edge.

## Timing
- Start detection: 2 cycles of synchronizer latency from an `rxd` fall.
- Samples at CLKS_PER_BIT/2 + k·CLKS_PER_BIT after the detected edge, for k = 1..9 (k=9 is stop), or k = 1..10 with parity.
- `data_valid` rises on the cycle after the stop sample.
- Error pulses are exactly one cycle wide, on the cycle after the offending sample.
- Back-to-back frames are received with no idle bits between them. A new start bit can be detected from IDLE on the cycle after the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state, the `parity_err` port and the parity check are compiled in.
  - A frame is 11 bits.
  - On a parity mismatch with a good stop bit: pulse `parity_err`, discard the byte. Neither `data_valid` nor `overrun` is affected.
- Undefined: 8N1 framing, 10 bits per frame; no PARITY state and no `parity_err` port.

## Structure
- Package `uart_pkg`:
  - FSM state typedef: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - `UART_DATA_W`=8.
  - Function computing the bit-timer width from CLKS_PER_BIT.
- Sub-module `uart_sync2`: 2-flop synchronizer with reset value 1. The FSM, timer and holding register live in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Frame 0x61 ('a'), `data_ready`=1 → `data`=0x61, `data_valid` high exactly 1 cycle, bits 7..0 = 01100001.
- Frames 0x48 then 0x7A back-to-back, `data_ready`=0 → `data`=0x48 held, `overrun` pulses once. Raising `data_ready` clears `data_valid`.
- `rxd` low for 5 cycles, then high → no `data_valid`, no error, FSM back in IDLE.
- Frame 0x41 with stop bit low, line low for 40 cycles → one `frame_err` pulse, no `data_valid`. The next good frame 0x42 is received correctly.
- Assert `rst_n`=0 during data bit 4 of frame 0x55 → outputs at reset values. The following frame 0x63 is received as 0x63.
- `UART_RX_PARITY_EN` defined:
  - Frame 0x03 with parity bit 1 → `parity_err` pulse, no `data_valid`.
  - Frame 0x03 with parity bit 0 → `data`=0x03, `data_valid`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared types, widths and helpers for the serial character receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // Width of an up-counting bit timer that must reach clks-1.
    function automatic int timer_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Purpose: two-flop synchronizer for the asynchronous serial line, idles high.
// Latency: 2 cycles from d to q.
// Backpressure: none.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // Both stages reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx_char.sv
// Purpose: 8N1 (optionally even parity, macro UART_RX_PARITY_EN) serial receiver with a one-entry output register.
// Latency: data_valid rises the cycle after the stop-bit sample; error pulses the cycle after the offending sample.
// Backpressure: a full holding register drops the next good character and pulses overrun.
module uart_rx_char
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxd,
    output logic [UART_DATA_W-1:0] data,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   frame_err,
    output logic                   overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int            TW      = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    logic                   rx_s;
    uart_state_e            state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   good_frame;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rx_s)
    );

    // Frame FSM: the timer counts up from the detected edge and is cleared at every sample point.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        good_frame  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (!rx_s) begin
                        // Low stop bit: report once, then sit out the rest of any break.
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end else begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) parity_err_d = 1'b1;
                        else                   good_frame   = 1'b1;
`else
                        good_frame = 1'b1;
`endif
                    end
                end
            end
            WAIT_HIGH: begin
                timer_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Holding register: a good frame loads only if the slot is empty or being drained this cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = good_frame && valid_q && !data_ready;
        if (good_frame && (!valid_q || data_ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset abandons any partial frame silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_char.sv
// Purpose: directed self-checking bench for uart_rx_char with a character scoreboard.
// Latency: n/a.
// Backpressure: data_ready driven per step.
module tb_uart_rx_char;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int vcnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic [8:0] exp_q[$];

    uart_rx_char #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: pulse-cycle counters and scoreboard pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) vcnt++;
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (data_valid && data_ready) begin
                logic [8:0] exp;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                last_data = data;
                check("sb_data", {23'd0, 1'b0, data}, {23'd0, exp});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rxd = b;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(par_b);
`else
        if (par_b === 1'bx) rxd = 1'b1;
`endif
        bit_out(stop_b);
        rxd = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
        check(tag, exp_q.size(), 0);
    endtask

    int vb, fb, ob, pb;

    initial begin
        // Reset state
        cycles(3);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        cycles(5);

        // 'a' with consumer ready: valid exactly one cycle
        data_ready = 1'b1;
        vb = vcnt;
        exp_q.push_back(9'h061);
        send_frame(8'h61, 1'b1, 1'b0);
        cycles(10);
        wait_drain("a_drain");
        check("a_valid_cycles", vcnt - vb, 1);
        check("a_bits", {24'd0, last_data}, 32'b01100001);

        // Back-to-back with consumer stalled: first held, second overruns
        data_ready = 1'b0;
        ob = ov_cnt;
        exp_q.push_back(9'h048);
        send_frame(8'h48, 1'b1, 1'b0);
        send_frame(8'h7A, 1'b1, 1'b0);
        cycles(5);
        check("ovr_pulses", ov_cnt - ob, 1);
        check("ovr_valid_held", {31'd0, data_valid}, 32'd1);
        check("ovr_data_held", {24'd0, data}, 32'h48);
        data_ready = 1'b1;
        cycles(2);
        wait_drain("ovr_drain");
        check("ovr_valid_clear", {31'd0, data_valid}, 32'd0);

        // Short low glitch: no character, no error
        vb = vcnt; fb = fe_cnt;
        rxd = 1'b0;
        cycles(5);
        rxd = 1'b1;
        cycles(30);
        check("glitch_valid", vcnt - vb, 0);
        check("glitch_err", fe_cnt - fb, 0);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));

        // Low stop bit followed by a break: one frame error, then recovery
        vb = vcnt; fb = fe_cnt;
        send_frame(8'h41, 1'b0, 1'b0);
        rxd = 1'b0;
        cycles(40);
        rxd = 1'b1;
        cycles(20);
        check("ferr_pulses", fe_cnt - fb, 1);
        check("ferr_valid", vcnt - vb, 0);
        exp_q.push_back(9'h042);
        send_frame(8'h42, 1'b1, 1'b0);
        cycles(5);
        wait_drain("ferr_recover");

        // Reset during data bit 4 of 0x55
        vb = vcnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(i[0] ? 1'b0 : 1'b1);
        rxd = 1'b1;
        cycles(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", {24'd0, data}, 32'h00);
        check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        check("mid_rst_no_char", vcnt - vb, 0);
        exp_q.push_back(9'h063);
        send_frame(8'h63, 1'b1, 1'b0);
        cycles(5);
        wait_drain("mid_rst_recover");

`ifdef UART_RX_PARITY_EN
        // Odd total ones: parity error, character dropped
        vb = vcnt; pb = pe_cnt; ob = ov_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        cycles(5);
        check("par_err_pulses", pe_cnt - pb, 1);
        check("par_err_valid", vcnt - vb, 0);
        check("par_err_overrun", ov_cnt - ob, 0);
        exp_q.push_back(9'h003);
        send_frame(8'h03, 1'b1, 1'b0);
        cycles(5);
        wait_drain("par_ok");
        check("par_ok_no_err", pe_cnt - pb, 1);
`endif

        check("sb_empty_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
